// File: rtl/comparator_sweep_checker_if.sv
// comparator_sweep_checker_if: operand/result bus between the sweep checker and the comparator under test
interface comparator_sweep_checker_if #(parameter int WIDTH = 4);
    logic [WIDTH-1:0] Data_out_A;
    logic [WIDTH-1:0] Data_out_B;
    logic             greater_in;
    logic             lesser_in;
    modport master (output Data_out_A, Data_out_B, input greater_in, lesser_in);
    modport slave  (input Data_out_A, Data_out_B, output greater_in, lesser_in);
endinterface

// File: rtl/comparator_sweep_checker.sv
// comparator_sweep_checker: sweeps every (A,B) pair into a magnitude comparator and checks greater/lesser.
// Define COMP_STOP_ON_FAIL_EN to end the sweep at the first mismatching pair.
module comparator_sweep_checker #(
    parameter int WIDTH = 4,
    parameter int LAT   = 0,
    parameter int ERR_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    comparator_sweep_checker_if.master cmp,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [ERR_W-1:0]           err_count,
    output logic [WIDTH-1:0]           fail_A,
    output logic [WIDTH-1:0]           fail_B
);
    typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, DONE} state_t;
    localparam int WC_W = (LAT > 1) ? $clog2(LAT) : 1;
    state_t               state, state_nx;
    logic [2*WIDTH-1:0]   idx;
    logic [WC_W-1:0]      wcnt;
    logic                 exp_g, exp_l, mismatch, last, launch;
    assign exp_g    = cmp.Data_out_A > cmp.Data_out_B;
    assign exp_l    = cmp.Data_out_A < cmp.Data_out_B;
    assign mismatch = (cmp.greater_in != exp_g) || (cmp.lesser_in != exp_l);
    assign last     = &idx;
    assign launch   = start && (state == IDLE || state == DONE);
    assign busy     = (state == DRIVE) || (state == WAIT) || (state == CHECK);
    assign done     = state == DONE;
    assign pass     = done && (err_count == '0);
    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    // next-state: one DRIVE, LAT WAIT cycles, one CHECK per pair
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: state_nx = start ? DRIVE : state;
            DRIVE:      state_nx = (LAT == 0) ? CHECK : WAIT;
            WAIT:       state_nx = (wcnt == WC_W'(LAT - 1)) ? CHECK : WAIT;
`ifdef COMP_STOP_ON_FAIL_EN
            CHECK:      state_nx = (last || mismatch) ? DONE : DRIVE;
`else
            CHECK:      state_nx = last ? DONE : DRIVE;
`endif
            default:    state_nx = IDLE;
        endcase
    end
    // pair counter, operand registers, error bookkeeping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx            <= '0;
            wcnt           <= '0;
            cmp.Data_out_A <= '0;
            cmp.Data_out_B <= '0;
            err_count      <= '0;
            fail_A         <= '0;
            fail_B         <= '0;
        end else begin
            if (launch) begin
                idx       <= '0;
                err_count <= '0;
                fail_A    <= '0;
                fail_B    <= '0;
            end
            if (state == DRIVE) begin
                cmp.Data_out_A <= idx[2*WIDTH-1:WIDTH];
                cmp.Data_out_B <= idx[WIDTH-1:0];
                wcnt           <= '0;
            end
            if (state == WAIT) wcnt <= wcnt + 1'b1;
            if (state == CHECK) begin
                idx <= idx + 1'b1;
                if (mismatch && err_count != '1) err_count <= err_count + 1'b1;
                if (mismatch && err_count == '0) begin
                    fail_A <= cmp.Data_out_A;
                    fail_B <= cmp.Data_out_B;
                end
            end
        end
    end
endmodule

// File: tb/tb_comparator_sweep_checker.sv
// tb_comparator_sweep_checker: directed table of comparator faults plus reset and latency sequences
module tb_comparator_sweep_checker;
    logic clk = 0, rst_n = 0, start0 = 0, start2 = 0;
    int   fault = 0;
    int   n_chk = 0, n_fail = 0;
    logic busy0, done0, pass0, busy2, done2, pass2;
    logic [15:0] err0, err2;
    logic [3:0]  fa0, fb0, fa2, fb2;
    logic g1, l1, g2, l2;
    always #5 clk = ~clk;
    comparator_sweep_checker_if #(.WIDTH(4)) i0 ();
    comparator_sweep_checker_if #(.WIDTH(4)) i2 ();
    comparator_sweep_checker #(.WIDTH(4), .LAT(0), .ERR_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .cmp(i0.master),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .fail_A(fa0), .fail_B(fb0));
    comparator_sweep_checker #(.WIDTH(4), .LAT(2), .ERR_W(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .cmp(i2.master),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .fail_A(fa2), .fail_B(fb2));
    // combinational comparator with selectable fault
    always_comb begin
        i0.greater_in = i0.Data_out_A > i0.Data_out_B;
        i0.lesser_in  = i0.Data_out_A < i0.Data_out_B;
        if (fault == 1) i0.greater_in = 1'b0;
        if (fault == 2 && i0.Data_out_A == 4'd10 && i0.Data_out_B == 4'd12) i0.greater_in = 1'b1;
        if (fault == 3 && i0.Data_out_A == 4'd15 && i0.Data_out_B == 4'd11) i0.greater_in = 1'b0;
    end
    // correct comparator with two register stages
    always @(posedge clk) begin
        g1 <= i2.Data_out_A > i2.Data_out_B;
        l1 <= i2.Data_out_A < i2.Data_out_B;
        g2 <= g1;
        l2 <= l1;
    end
    assign i2.greater_in = g2;
    assign i2.lesser_in  = l2;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask
    task automatic run0(output int cyc);
        @(negedge clk) start0 = 1;
        @(negedge clk) start0 = 0;
        cyc = 0;
        while (!done0 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
    endtask
    typedef struct {
        int mode; int cyc; int ps; int err; int fa; int fb; int oa; int ob;
    } vec_t;
`ifdef COMP_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif
    vec_t vecs[4];
    initial begin
        int cyc;
        vecs[0] = '{0, 512, 1, 0, 0, 0, 15, 15};
        vecs[1] = STOP ? '{1, 34, 0, 1, 1, 0, 1, 0}     : '{1, 512, 0, 120, 1, 0, 15, 15};
        vecs[2] = STOP ? '{2, 346, 0, 1, 10, 12, 10, 12} : '{2, 512, 0, 1, 10, 12, 15, 15};
        vecs[3] = STOP ? '{3, 504, 0, 1, 15, 11, 15, 11} : '{3, 512, 0, 1, 15, 11, 15, 15};
        repeat (3) @(negedge clk);
        chk("reset busy", busy0, 0);
        chk("reset done", done0, 0);
        chk("reset pass", pass0, 0);
        chk("reset err", err0, 0);
        chk("reset fail_A", fa0, 0);
        chk("reset fail_B", fb0, 0);
        chk("reset A", i0.Data_out_A, 0);
        chk("reset B", i0.Data_out_B, 0);
        chk("reset busy lat2", busy2, 0);
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            fault = vecs[i].mode;
            run0(cyc);
            chk($sformatf("v%0d cycles", i), cyc, vecs[i].cyc);
            chk($sformatf("v%0d busy", i), busy0, 0);
            chk($sformatf("v%0d done", i), done0, 1);
            chk($sformatf("v%0d pass", i), pass0, vecs[i].ps);
            chk($sformatf("v%0d err", i), err0, vecs[i].err);
            chk($sformatf("v%0d fail_A", i), fa0, vecs[i].fa);
            chk($sformatf("v%0d fail_B", i), fb0, vecs[i].fb);
            chk($sformatf("v%0d A", i), i0.Data_out_A, vecs[i].oa);
            chk($sformatf("v%0d B", i), i0.Data_out_B, vecs[i].ob);
            repeat (3) @(negedge clk);
            chk($sformatf("v%0d done held", i), done0, 1);
        end
        // reset in the middle of a sweep, then restart from 0,0
        fault = 0;
        @(negedge clk) start0 = 1;
        @(negedge clk) start0 = 0;
        cyc = 0;
        while (i0.Data_out_A != 4'd5 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        chk("midsweep reached A=5", i0.Data_out_A, 5);
        chk("midsweep busy", busy0, 1);
        rst_n = 0;
        @(negedge clk) rst_n = 1;
        chk("midrst busy", busy0, 0);
        chk("midrst done", done0, 0);
        chk("midrst A", i0.Data_out_A, 0);
        chk("midrst B", i0.Data_out_B, 0);
        @(negedge clk) start0 = 1;
        @(negedge clk) start0 = 0;
        chk("restart busy", busy0, 1);
        @(negedge clk);
        chk("restart A0", i0.Data_out_A, 0);
        chk("restart B0", i0.Data_out_B, 0);
        repeat (2) @(negedge clk);
        chk("restart A1", i0.Data_out_A, 0);
        chk("restart B1", i0.Data_out_B, 1);
        // start coincident with reset: reset wins
        @(negedge clk) begin rst_n = 0; start0 = 1; end
        @(negedge clk) begin rst_n = 1; start0 = 0; end
        chk("rst+start busy", busy0, 0);
        @(negedge clk);
        chk("rst+start idle", busy0, 0);
        // two-cycle latency comparator, extra starts while busy ignored
        @(negedge clk) start2 = 1;
        @(negedge clk) start2 = 0;
        cyc = 0;
        while (!done2 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 100 || cyc == 700) start2 = 1;
            else start2 = 0;
        end
        chk("lat2 cycles", cyc, 1024);
        chk("lat2 done", done2, 1);
        chk("lat2 pass", pass2, 1);
        chk("lat2 err", err2, 0);
        chk("lat2 fail_A", fa2, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
